// File: rtl/commutation_monitor.sv
// commutation_monitor
//   Watches the 6-bit gate vector between the commutation FSM and the gate
//   drivers. Decodes the connected source phase and checks each step:
//   no source short, no open inductive load, bounded transit time and a
//   minimum hold time for each intermediate pattern. The first fault is
//   latched and mirrored on short_req so the FSM is forced to all-off.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   armed        in   converter running (same signal as FSM start)
//   clr          in   synchronous fault clear, honoured only while disarmed
//   gates[5:0]   in   [5]A_p [4]A_n [3]B_p [2]B_n [1]C_p [0]C_n
//   load_phase   out  01 A, 10 B, 11 C, 00 none/partial (registered)
//   steady       out  monitor in STEADY state (registered)
//   fault        out  latched fault flag (registered)
//   fault_code   out  001 short, 010 open, 011 timeout, 100 dwell
//   short_req    out  same as fault, drives the FSM Short input
//   commutations out  completed phase changes, wraps
module commutation_monitor #(
  parameter int MAX_TRANSIT = 8,
  parameter int MIN_DWELL   = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             armed,
  input  logic             clr,
  input  logic [5:0]       gates,
  output logic [1:0]       load_phase,
  output logic             steady,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             short_req,
  output logic [CNT_W-1:0] commutations
);

  // Transit counter only has to represent MAX_TRANSIT+1 before the fault fires.
  localparam int TW = $clog2(MAX_TRANSIT + 2);
  localparam logic [TW-1:0] TMAX = TW'(MAX_TRANSIT);
  localparam logic [7:0]    DMIN = 8'(MIN_DWELL);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_STEADY  = 2'b01,
    S_TRANSIT = 2'b10,
    S_FAULT   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    C_ZERO    = 2'b00,
    C_STEADY  = 2'b01,
    C_INTER   = 2'b10,
    C_ILLEGAL = 2'b11
  } class_t;

  localparam logic [2:0] F_NONE    = 3'b000;
  localparam logic [2:0] F_SHORT   = 3'b001;
  localparam logic [2:0] F_OPEN    = 3'b010;
  localparam logic [2:0] F_TIMEOUT = 3'b011;
  localparam logic [2:0] F_DWELL   = 3'b100;

  function automatic logic one_hot3(input logic [2:0] x);
    return (x == 3'b001) || (x == 3'b010) || (x == 3'b100);
  endfunction

  function automatic logic two_hot3(input logic [2:0] x);
    return (x == 3'b011) || (x == 3'b101) || (x == 3'b110);
  endfunction

  // Split into p-side and n-side triples (A,B,C order) and classify.
  function automatic class_t classify(input logic [5:0] g);
    logic [2:0] p;
    logic [2:0] n;
    p = {g[5], g[3], g[1]};
    n = {g[4], g[2], g[0]};
    if (g == 6'b000000) begin
      return C_ZERO;
    end else if ((p == n) && one_hot3(p)) begin
      return C_STEADY;
    end else if (((one_hot3(p) || two_hot3(p)) && (n == 3'b000)) ||
                 ((one_hot3(n) || two_hot3(n)) && (p == 3'b000))) begin
      return C_INTER;
    end else begin
      return C_ILLEGAL;
    end
  endfunction

  // Phase of a STEADY pattern; meaningless for other classes.
  function automatic logic [1:0] phase_of(input logic [5:0] g);
    logic [1:0] ph;
    case ({g[5], g[3], g[1]})
      3'b100:  ph = 2'b01;
      3'b010:  ph = 2'b10;
      3'b001:  ph = 2'b11;
      default: ph = 2'b00;
    endcase
    return ph;
  endfunction

  state_t           r_state;
  logic [1:0]       r_last_phase;
  logic [TW-1:0]    r_transit_cnt;
  logic [5:0]       r_prev_gates;
  logic [7:0]       r_dwell_cnt;
  logic [1:0]       r_load_phase;
  logic             r_steady;
  logic             r_fault;
  logic [2:0]       r_fault_code;
  logic [CNT_W-1:0] r_comm;

  state_t        w_state_nxt;
  class_t        w_cls;
  class_t        w_prev_cls;
  logic [1:0]    w_phase;
  logic [1:0]    w_live_phase;
  logic [1:0]    w_last_nxt;
  logic [TW-1:0] w_transit_nxt;
  logic [TW-1:0] w_tinc;
  logic [7:0]    w_dwell_nxt;
  logic          w_changed;
  logic          w_dwell_viol;
  logic          w_comm_inc;
  logic [2:0]    w_code_nxt;

  assign w_cls        = classify(gates);
  assign w_prev_cls   = classify(r_prev_gates);
  assign w_phase      = phase_of(gates);
  assign w_live_phase = (w_cls == C_STEADY) ? w_phase : 2'b00;
  assign w_changed    = (gates != r_prev_gates);
  assign w_tinc       = (r_transit_cnt == {TW{1'b1}}) ? r_transit_cnt : (r_transit_cnt + TW'(1));
  assign w_dwell_nxt  = w_changed ? 8'd1 :
                        ((r_dwell_cnt == 8'hFF) ? r_dwell_cnt : (r_dwell_cnt + 8'd1));
  // An intermediate pattern left before it was held long enough.
  assign w_dwell_viol = w_changed && (w_prev_cls == C_INTER) && (r_dwell_cnt < DMIN);

  // Next state, fault code and step bookkeeping.
  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last_phase;
    w_transit_nxt = r_transit_cnt;
    w_comm_inc    = 1'b0;
    w_code_nxt    = r_fault_code;
    case (r_state)
      S_IDLE: begin
        if (armed) begin
          case (w_cls)
            C_STEADY: begin
              w_state_nxt = S_STEADY;
              w_last_nxt  = w_phase;
            end
            C_INTER: begin
              w_state_nxt   = S_TRANSIT;
              w_transit_nxt = TW'(1);
            end
            C_ILLEGAL: begin
              w_state_nxt = S_FAULT;
              w_code_nxt  = F_SHORT;
            end
            default: w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STEADY: begin
        if (!armed) begin
          w_state_nxt = S_IDLE;
        end else begin
          case (w_cls)
            C_STEADY: begin
              // A different steady phase without intermediates is a direct swap.
              w_state_nxt = S_STEADY;
              if (w_phase != r_last_phase) begin
                w_comm_inc = 1'b1;
                w_last_nxt = w_phase;
              end else begin
                w_comm_inc = 1'b0;
              end
            end
            C_INTER: begin
              w_state_nxt   = S_TRANSIT;
              w_transit_nxt = TW'(1);
            end
            C_ZERO: begin
              w_state_nxt = S_FAULT;
              w_code_nxt  = F_OPEN;
            end
            default: begin
              w_state_nxt = S_FAULT;
              w_code_nxt  = F_SHORT;
            end
          endcase
        end
      end
      S_TRANSIT: begin
        if (!armed) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_transit_nxt = w_tinc;
          // Priority chain: short, open, timeout, dwell.
          if (w_cls == C_ILLEGAL) begin
            w_state_nxt = S_FAULT;
            w_code_nxt  = F_SHORT;
          end else if (w_cls == C_ZERO) begin
            w_state_nxt = S_FAULT;
            w_code_nxt  = F_OPEN;
          end else if ((w_cls == C_INTER) && (w_tinc > TMAX)) begin
            w_state_nxt = S_FAULT;
            w_code_nxt  = F_TIMEOUT;
          end else if (w_dwell_viol) begin
            w_state_nxt = S_FAULT;
            w_code_nxt  = F_DWELL;
          end else if (w_cls == C_STEADY) begin
            w_state_nxt = S_STEADY;
            w_last_nxt  = w_phase;
            w_comm_inc  = (w_phase != r_last_phase);
          end else begin
            w_state_nxt = S_TRANSIT;
          end
        end
      end
      S_FAULT: begin
        if (clr && !armed) begin
          w_state_nxt = S_IDLE;
          w_code_nxt  = F_NONE;
        end else begin
          w_state_nxt = S_FAULT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, pattern history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_phase  <= 2'b00;
      r_transit_cnt <= '0;
      r_prev_gates  <= 6'b000000;
      r_dwell_cnt   <= 8'd0;
      r_load_phase  <= 2'b00;
      r_steady      <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_code  <= F_NONE;
      r_comm        <= '0;
    end else begin
      r_last_phase  <= w_last_nxt;
      r_transit_cnt <= w_transit_nxt;
      r_prev_gates  <= gates;
      r_dwell_cnt   <= w_dwell_nxt;
      r_load_phase  <= w_live_phase;
      r_steady      <= (w_state_nxt == S_STEADY);
      r_fault       <= (w_state_nxt == S_FAULT);
      r_fault_code  <= w_code_nxt;
      r_comm        <= w_comm_inc ? (r_comm + CNT_W'(1)) : r_comm;
    end
  end

  assign load_phase   = r_load_phase;
  assign steady       = r_steady;
  assign fault        = r_fault;
  assign fault_code   = r_fault_code;
  assign short_req    = r_fault;
  assign commutations = r_comm;

endmodule

// File: tb/tb_commutation_monitor.sv
// Self-checking bench for commutation_monitor: a directed vector table on the
// default instance, a hand-written dwell sequence on a MIN_DWELL=2 instance,
// then randomized stimulus on both against a behavioural model.
module tb_commutation_monitor;

  logic       clk;
  logic       rst;
  logic       armed;
  logic       clr;
  logic [5:0] gates;

  logic [1:0] lp1, lp2;
  logic       st1, st2, f1, f2, sr1, sr2;
  logic [2:0] fc1, fc2;
  logic [7:0] cm1, cm2;

  int checks = 0;
  int errors = 0;

  commutation_monitor u_dut (
    .clk(clk), .rst(rst), .armed(armed), .clr(clr), .gates(gates),
    .load_phase(lp1), .steady(st1), .fault(f1), .fault_code(fc1),
    .short_req(sr1), .commutations(cm1)
  );

  commutation_monitor #(.MIN_DWELL(2)) u_dw (
    .clk(clk), .rst(rst), .armed(armed), .clr(clr), .gates(gates),
    .load_phase(lp2), .steady(st2), .fault(f2), .fault_code(fc2),
    .short_req(sr2), .commutations(cm2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       a;
    logic       c;
    logic [5:0] g;
    logic [1:0] lp;
    logic       st;
    logic       f;
    logic [2:0] code;
    logic [7:0] comm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, a, c, input logic [5:0] g,
                              input logic [1:0] lp, input logic st, f,
                              input logic [2:0] code, input logic [7:0] comm);
    vec_t v;
    v.r = r; v.a = a; v.c = c; v.g = g;
    v.lp = lp; v.st = st; v.f = f; v.code = code; v.comm = comm;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  localparam int M_IDLE = 0, M_STEADY = 1, M_TRANSIT = 2, M_FAULT = 3;
  localparam int K_ZERO = 0, K_STEADY = 1, K_INTER = 2, K_ILLEGAL = 3;
  localparam int MAXT = 8;

  typedef struct {
    int         st;
    int         last;
    int         tcnt;
    logic [5:0] prev;
    int         dwell;
    logic [2:0] code;
    logic [7:0] comm;
    logic [1:0] lp;
  } mdl_t;

  mdl_t m1, m2;

  function automatic int gclass(input logic [5:0] g);
    int np, nn;
    np = $countones({g[5], g[3], g[1]});
    nn = $countones({g[4], g[2], g[0]});
    if (g == 6'b000000) return K_ZERO;
    if (g == 6'b110000 || g == 6'b001100 || g == 6'b000011) return K_STEADY;
    if ((np + nn == 1) || (np == 2 && nn == 0) || (nn == 2 && np == 0)) return K_INTER;
    return K_ILLEGAL;
  endfunction

  function automatic int gphase(input logic [5:0] g);
    if (g == 6'b110000) return 1;
    if (g == 6'b001100) return 2;
    if (g == 6'b000011) return 3;
    return 0;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input logic r, a, c,
                                 input logic [5:0] g, input int min_dw);
    mdl_t n;
    int cls, pcls, ph, tinc;
    bit chg;
    n = m;
    cls = gclass(g);
    ph  = (cls == K_STEADY) ? gphase(g) : 0;
    if (r) begin
      n.st = M_IDLE; n.last = 0; n.tcnt = 0; n.prev = 6'b000000;
      n.dwell = 0; n.code = 3'b000; n.comm = 8'd0; n.lp = 2'b00;
      return n;
    end
    n.lp = 2'(ph);
    chg  = (g != m.prev);
    pcls = gclass(m.prev);
    n.prev  = g;
    n.dwell = chg ? 1 : m.dwell + 1;
    case (m.st)
      M_IDLE: begin
        if (a && cls == K_STEADY) begin n.st = M_STEADY; n.last = ph; end
        else if (a && cls == K_INTER) begin n.st = M_TRANSIT; n.tcnt = 1; end
        else if (a && cls == K_ILLEGAL) begin n.st = M_FAULT; n.code = 3'b001; end
      end
      M_STEADY: begin
        if (!a) n.st = M_IDLE;
        else if (cls == K_STEADY) begin
          if (ph != m.last) begin n.comm = m.comm + 8'd1; n.last = ph; end
        end
        else if (cls == K_INTER) begin n.st = M_TRANSIT; n.tcnt = 1; end
        else if (cls == K_ZERO) begin n.st = M_FAULT; n.code = 3'b010; end
        else begin n.st = M_FAULT; n.code = 3'b001; end
      end
      M_TRANSIT: begin
        if (!a) n.st = M_IDLE;
        else begin
          tinc = m.tcnt + 1;
          n.tcnt = tinc;
          if (cls == K_ILLEGAL) begin n.st = M_FAULT; n.code = 3'b001; end
          else if (cls == K_ZERO) begin n.st = M_FAULT; n.code = 3'b010; end
          else if (cls == K_INTER && tinc > MAXT) begin n.st = M_FAULT; n.code = 3'b011; end
          else if (chg && pcls == K_INTER && m.dwell < min_dw) begin
            n.st = M_FAULT; n.code = 3'b100;
          end
          else if (cls == K_STEADY) begin
            n.st = M_STEADY;
            if (ph != m.last) n.comm = m.comm + 8'd1;
            n.last = ph;
          end
        end
      end
      default: begin
        if (c && !a) begin n.st = M_IDLE; n.code = 3'b000; end
      end
    endcase
    return n;
  endfunction

  // ---------------- helpers ----------------
  task automatic step(input logic r, a, c, input logic [5:0] g);
    rst = r; armed = a; clr = c; gates = g;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [1:0] lp, input logic st, f, input logic [2:0] code,
                     input logic sr, input logic [7:0] cm,
                     input logic [1:0] elp, input logic est, ef, input logic [2:0] ecode,
                     input logic [7:0] ecm);
    checks++;
    if ({lp, st, f, code, sr, cm} !== {elp, est, ef, ecode, ef, ecm}) begin
      errors++;
      $display("FAIL %s: got lp=%b st=%b f=%b code=%b sr=%b comm=%0d, want lp=%b st=%b f=%b code=%b sr=%b comm=%0d",
               nm, lp, st, f, code, sr, cm, elp, est, ef, ecode, ef, ecm);
    end
  endtask

  logic [5:0] inter_pat [12];
  logic [5:0] steady_pat [3];

  initial begin
    rst = 1'b1; armed = 1'b0; clr = 1'b0; gates = 6'b000000;

    // ---- directed table on the default instance ----
    tbl.push_back(mk(1,0,0,6'b000000, 2'b00,0,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b110000, 2'b01,1,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b110000, 2'b01,1,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b110000, 2'b01,1,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b100000, 2'b00,0,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b101000, 2'b00,0,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b001000, 2'b00,0,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b001100, 2'b10,1,0,3'b000,8'd1));
    tbl.push_back(mk(0,1,0,6'b000011, 2'b11,1,0,3'b000,8'd2));  // direct swap B->C
    tbl.push_back(mk(0,1,0,6'b110000, 2'b01,1,0,3'b000,8'd3));  // direct swap C->A
    tbl.push_back(mk(0,1,0,6'b100100, 2'b00,0,1,3'b001,8'd3));  // short
    tbl.push_back(mk(0,1,0,6'b000000, 2'b00,0,1,3'b001,8'd3));  // first fault kept
    tbl.push_back(mk(0,1,1,6'b000000, 2'b00,0,1,3'b001,8'd3));  // clr ignored while armed
    tbl.push_back(mk(0,0,1,6'b000000, 2'b00,0,0,3'b000,8'd3));  // clr when disarmed
    tbl.push_back(mk(1,1,0,6'b110000, 2'b00,0,0,3'b000,8'd0));  // rst wins
    tbl.push_back(mk(0,1,0,6'b110000, 2'b01,1,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b000000, 2'b00,0,1,3'b010,8'd0));  // open
    tbl.push_back(mk(1,0,0,6'b000000, 2'b00,0,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b110000, 2'b01,1,0,3'b000,8'd0));
    tbl.push_back(mk(0,0,0,6'b000000, 2'b00,0,0,3'b000,8'd0));  // disarm: no open fault
    tbl.push_back(mk(0,0,0,6'b110000, 2'b01,0,0,3'b000,8'd0));  // idle, live decode
    tbl.push_back(mk(0,1,0,6'b110000, 2'b01,1,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b100000, 2'b00,0,0,3'b000,8'd0));
    tbl.push_back(mk(0,0,0,6'b100000, 2'b00,0,0,3'b000,8'd0));  // disarm in transit
    tbl.push_back(mk(1,0,0,6'b000000, 2'b00,0,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b111000, 2'b00,0,1,3'b001,8'd0));  // illegal from idle
    // timeout: 9 intermediate cycles
    tbl.push_back(mk(1,0,0,6'b000000, 2'b00,0,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b110000, 2'b01,1,0,3'b000,8'd0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0,1,0,6'b100000, 2'b00,0,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b100000, 2'b00,0,1,3'b011,8'd0));
    // 8 intermediate cycles then arrive: legal
    tbl.push_back(mk(1,0,0,6'b000000, 2'b00,0,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b110000, 2'b01,1,0,3'b000,8'd0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0,1,0,6'b100000, 2'b00,0,0,3'b000,8'd0));
    tbl.push_back(mk(0,1,0,6'b001100, 2'b10,1,0,3'b000,8'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].a, tbl[i].c, tbl[i].g);
      chk($sformatf("vec%0d", i), lp1, st1, f1, fc1, sr1, cm1,
          tbl[i].lp, tbl[i].st, tbl[i].f, tbl[i].code, tbl[i].comm);
    end

    // ---- dwell sequence on the MIN_DWELL=2 instance ----
    step(1,0,0,6'b000000); chk("dw_rst",   lp2,st2,f2,fc2,sr2,cm2, 2'b00,0,0,3'b000,8'd0);
    step(0,1,0,6'b110000); chk("dw_sa",    lp2,st2,f2,fc2,sr2,cm2, 2'b01,1,0,3'b000,8'd0);
    step(0,1,0,6'b100000); chk("dw_i1",    lp2,st2,f2,fc2,sr2,cm2, 2'b00,0,0,3'b000,8'd0);
    step(0,1,0,6'b101000); chk("dw_fault", lp2,st2,f2,fc2,sr2,cm2, 2'b00,0,1,3'b100,8'd0);
    step(0,1,1,6'b000000); chk("dw_clr_a", lp2,st2,f2,fc2,sr2,cm2, 2'b00,0,1,3'b100,8'd0);
    step(0,0,1,6'b000000); chk("dw_clr",   lp2,st2,f2,fc2,sr2,cm2, 2'b00,0,0,3'b000,8'd0);
    step(0,1,0,6'b110000); chk("dw_sa2",   lp2,st2,f2,fc2,sr2,cm2, 2'b01,1,0,3'b000,8'd0);
    step(0,1,0,6'b100000);
    step(0,1,0,6'b100000);
    step(0,1,0,6'b101000);
    step(0,1,0,6'b101000);
    step(0,1,0,6'b001000); chk("dw_held",  lp2,st2,f2,fc2,sr2,cm2, 2'b00,0,0,3'b000,8'd0);
    step(0,1,0,6'b001000);
    step(0,1,0,6'b001100); chk("dw_arrive",lp2,st2,f2,fc2,sr2,cm2, 2'b10,1,0,3'b000,8'd1);

    // ---- randomized run against the model ----
    steady_pat[0] = 6'b110000; steady_pat[1] = 6'b001100; steady_pat[2] = 6'b000011;
    inter_pat[0]  = 6'b100000; inter_pat[1]  = 6'b010000; inter_pat[2]  = 6'b001000;
    inter_pat[3]  = 6'b000100; inter_pat[4]  = 6'b000010; inter_pat[5]  = 6'b000001;
    inter_pat[6]  = 6'b101000; inter_pat[7]  = 6'b100010; inter_pat[8]  = 6'b001010;
    inter_pat[9]  = 6'b010100; inter_pat[10] = 6'b010001; inter_pat[11] = 6'b000101;

    step(1,0,0,6'b000000);
    m1 = mstep(m1, 1'b1, 1'b0, 1'b0, 6'b000000, 1);
    m2 = mstep(m2, 1'b1, 1'b0, 1'b0, 6'b000000, 2);
    begin
      int hold;
      logic [5:0] g;
      logic r, a, c;
      int sel;
      hold = 0;
      g = 6'b000000;
      for (int i = 0; i < 3000; i++) begin
        if (hold == 0) begin
          sel = $urandom_range(0, 15);
          if (sel < 6)        g = steady_pat[$urandom_range(0, 2)];
          else if (sel < 12)  g = inter_pat[$urandom_range(0, 11)];
          else if (sel == 12) g = 6'b000000;
          else                g = 6'($urandom);
          hold = $urandom_range(1, 4);
        end
        hold--;
        r = ($urandom_range(0, 199) == 0);
        a = ($urandom_range(0, 19) != 0);
        c = ($urandom_range(0, 7) == 0);
        step(r, a, c, g);
        m1 = mstep(m1, r, a, c, g, 1);
        m2 = mstep(m2, r, a, c, g, 2);
        chk($sformatf("rand1_%0d", i), lp1, st1, f1, fc1, sr1, cm1,
            m1.lp, (m1.st == M_STEADY), (m1.st == M_FAULT), m1.code, m1.comm);
        chk($sformatf("rand2_%0d", i), lp2, st2, f2, fc2, sr2, cm2,
            m2.lp, (m2.st == M_STEADY), (m2.st == M_FAULT), m2.code, m2.comm);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
